// File: rtl/mgmt_pkg.sv
`default_nettype none
// ============================================================================
// Package : mgmt_pkg
// Purpose : Shared codes and types for the management RX path.
// Rev     : 1.0
// ============================================================================
package mgmt_pkg;

    localparam int PKT_W  = 139;
    localparam int WORD_W = 36;

    // Line header codes, rx_pkt[138:136]
    localparam logic [2:0] HDR_HEAD = 3'b101;
    localparam logic [2:0] HDR_MID  = 3'b100;
    localparam logic [2:0] HDR_TAIL = 3'b110;

    // Command word flags, cmd_pkt[35:34]
    localparam logic [1:0] W_FIRST = 2'b01;
    localparam logic [1:0] W_MID   = 2'b11;
    localparam logic [1:0] W_LAST  = 2'b10;

    localparam int MAX_PKT_WORDS = 384;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_DROP  = 2'd2,
        ST_WAIT  = 2'd3
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/mgmt_fifo.sv
`default_nettype none
// ============================================================================
// Module  : mgmt_fifo
// Purpose : Show-ahead synchronous FIFO; rdreq pops the entry currently on q.
// Rev     : 1.0
// ============================================================================
module mgmt_fifo #(
    parameter int AW = 8,
    parameter int DW = 139
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] data_i,
    input  logic          wrreq_i,
    input  logic          rdreq_i,
    output logic [DW-1:0] q_o,
    output logic          empty_o,
    output logic [AW-1:0] usedw_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          full, do_wr, do_rd;

    assign full    = cnt_q[AW];
    assign empty_o = (cnt_q == '0);
    assign do_wr   = wrreq_i && !full;
    assign do_rd   = rdreq_i && !empty_o;
    assign q_o     = mem_q[rp_q];
    assign usedw_o = cnt_q[AW-1:0];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wp_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_wr) begin
                wp_q <= wp_q + AW'(1);
            end
            if (do_rd) begin
                rp_q <= rp_q + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mgmt_line_splitter.sv
`default_nettype none
// ============================================================================
// Module  : mgmt_line_splitter
// Purpose : Word index, 128->32 mux and flag/byte-count for one 139-bit line.
// Rev     : 1.0
// ============================================================================
module mgmt_line_splitter
    import mgmt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [PKT_W-1:0]  line_i,
    input  logic              first_i,
    input  logic              adv_i,
    output logic [WORD_W-1:0] word_o,
    output logic              last_o,
    output logic              line_end_o
);

    logic [1:0]  w_q;
    logic [31:0] data;
    logic [1:0]  flag;
    logic [1:0]  bytes;
    logic        unused_rsvd;

    assign unused_rsvd = ^line_i[131:128];

    always_comb begin
        data = line_i[127:96];
        case (w_q)
            2'd0:    data = line_i[127:96];
            2'd1:    data = line_i[95:64];
            2'd2:    data = line_i[63:32];
            default: data = line_i[31:0];
        endcase
    end

    assign last_o     = (line_i[138:136] == HDR_TAIL) && (w_q == line_i[135:134]);
    assign line_end_o = last_o || (w_q == 2'd3);

    // The last flag takes priority so a one-word packet still closes.
    always_comb begin
        flag = W_MID;
        if (last_o) begin
            flag = W_LAST;
        end else if (first_i) begin
            flag = W_FIRST;
        end
    end

    assign bytes  = last_o ? 2'(line_i[133:132] + 2'd1) : 2'b00;
    assign word_o = {flag, bytes, data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q <= 2'd0;
        end else if (adv_i) begin
            w_q <= line_end_o ? 2'd0 : w_q + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/manage_rx.sv
`default_nettype none
// ============================================================================
// Module  : manage_rx
// Purpose : Management RX path: buffers packets plus verdicts, splits lines to command words.
// Rev     : 1.0
// ============================================================================
module manage_rx
    import mgmt_pkg::*;
#(
    parameter int PKT_FIFO_AW = 8,
    parameter int VLD_FIFO_AW = 6,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PKT_W-1:0]       rx_pkt,
    input  logic                   rx_pkt_wrreq,
    output logic [PKT_FIFO_AW-1:0] rx_pkt_usedw,
    input  logic                   rx_valid,
    input  logic                   rx_valid_wrreq,
    output logic [WORD_W-1:0]      cmd_pkt,
    output logic                   cmd_wr,
    output logic                   cmd_valid_wr,
    input  logic                   cmd_afull,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    rx_state_e              state_q, state_d;
    logic                   first_q, first_d;
    logic [WORD_W-1:0]      cmd_pkt_q;
    logic                   cmd_wr_q, cmd_valid_wr_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    logic [PKT_W-1:0]       pkt_q;
    logic                   pkt_empty, pkt_rd;
    logic [0:0]             vld_q;
    logic                   vld_empty, vld_rd;
    logic [VLD_FIFO_AW-1:0] unused_vld_usedw;

    logic [2:0]             hdr;
    logic [WORD_W-1:0]      word;
    logic                   last, line_end, adv, wr_d, vwr_d, err_inc;

    mgmt_fifo #(.AW(PKT_FIFO_AW), .DW(PKT_W)) u_pkt_fifo (
        .clk     (clk),
        .reset   (reset),
        .data_i  (rx_pkt),
        .wrreq_i (rx_pkt_wrreq),
        .rdreq_i (pkt_rd),
        .q_o     (pkt_q),
        .empty_o (pkt_empty),
        .usedw_o (rx_pkt_usedw)
    );

    mgmt_fifo #(.AW(VLD_FIFO_AW), .DW(1)) u_vld_fifo (
        .clk     (clk),
        .reset   (reset),
        .data_i  (rx_valid),
        .wrreq_i (rx_valid_wrreq),
        .rdreq_i (vld_rd),
        .q_o     (vld_q),
        .empty_o (vld_empty),
        .usedw_o (unused_vld_usedw)
    );

    mgmt_line_splitter u_splitter (
        .clk        (clk),
        .reset      (reset),
        .line_i     (pkt_q),
        .first_i    (first_q),
        .adv_i      (adv),
        .word_o     (word),
        .last_o     (last),
        .line_end_o (line_end)
    );

    assign hdr = pkt_q[138:136];

    // A one-line packet starts with a tail line, so both head and tail are legal first lines.
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        vld_rd  = 1'b0;
        pkt_rd  = 1'b0;
        adv     = 1'b0;
        wr_d    = 1'b0;
        vwr_d   = 1'b0;
        err_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!vld_empty && !cmd_afull) begin
                    vld_rd = 1'b1;
                    if (vld_q[0]) begin
                        state_d = ST_SPLIT;
                        first_d = 1'b1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_SPLIT: begin
                if (!pkt_empty) begin
                    if (first_q && (hdr != HDR_HEAD) && (hdr != HDR_TAIL)) begin
                        err_inc = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        adv     = 1'b1;
                        wr_d    = 1'b1;
                        first_d = 1'b0;
                        pkt_rd  = line_end;
                        if (last) begin
                            vwr_d   = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (!pkt_empty) begin
                    pkt_rd = 1'b1;
                    if (hdr == HDR_TAIL) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            first_q        <= 1'b0;
            cmd_pkt_q      <= '0;
            cmd_wr_q       <= 1'b0;
            cmd_valid_wr_q <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            first_q        <= first_d;
            cmd_wr_q       <= wr_d;
            cmd_valid_wr_q <= vwr_d;
            if (wr_d) begin
                cmd_pkt_q <= word;
            end
            if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    assign cmd_pkt      = cmd_pkt_q;
    assign cmd_wr       = cmd_wr_q;
    assign cmd_valid_wr = cmd_valid_wr_q;
    assign err_cnt      = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_manage_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_manage_rx
// Purpose : Scoreboard bench for manage_rx with directed packets.
// Rev     : 1.0
// ============================================================================
module tb_manage_rx;

    typedef struct packed {
        logic [35:0] word;
        logic        vwr;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [138:0] rx_pkt;
    logic         rx_pkt_wrreq;
    logic [7:0]   rx_pkt_usedw;
    logic         rx_valid;
    logic         rx_valid_wrreq;
    logic [35:0]  cmd_pkt;
    logic         cmd_wr;
    logic         cmd_valid_wr;
    logic         cmd_afull;
    logic [15:0]  err_cnt;

    logic [7:0]   unused_sat_usedw;
    logic [35:0]  unused_sat_cmd_pkt;
    logic         unused_sat_cmd_wr;
    logic         unused_sat_cmd_valid_wr;
    logic [1:0]   sat_err_cnt;

    int   n_vec      = 0;
    int   n_err      = 0;
    int   words_seen = 0;
    logic prev_open  = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    manage_rx dut (
        .clk            (clk),
        .reset          (reset),
        .rx_pkt         (rx_pkt),
        .rx_pkt_wrreq   (rx_pkt_wrreq),
        .rx_pkt_usedw   (rx_pkt_usedw),
        .rx_valid       (rx_valid),
        .rx_valid_wrreq (rx_valid_wrreq),
        .cmd_pkt        (cmd_pkt),
        .cmd_wr         (cmd_wr),
        .cmd_valid_wr   (cmd_valid_wr),
        .cmd_afull      (cmd_afull),
        .err_cnt        (err_cnt)
    );

    // Narrow error counter so saturation is reachable in a short run.
    manage_rx #(.ERR_CNT_W(2)) u_sat (
        .clk            (clk),
        .reset          (reset),
        .rx_pkt         (rx_pkt),
        .rx_pkt_wrreq   (rx_pkt_wrreq),
        .rx_pkt_usedw   (unused_sat_usedw),
        .rx_valid       (rx_valid),
        .rx_valid_wrreq (rx_valid_wrreq),
        .cmd_pkt        (unused_sat_cmd_pkt),
        .cmd_wr         (unused_sat_cmd_wr),
        .cmd_valid_wr   (unused_sat_cmd_valid_wr),
        .cmd_afull      (cmd_afull),
        .err_cnt        (sat_err_cnt)
    );

    // Monitor: pops an expectation for every presented word; flags gaps inside a packet.
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            prev_open = 1'b0;
        end else begin
            if (prev_open) begin
                n_vec++;
                if (cmd_wr !== 1'b1) begin
                    n_err++;
                    $display("FAIL gap: cmd_wr=%b mid-packet, required 1", cmd_wr);
                end
            end
            if (cmd_wr === 1'b1) begin
                exp_t e;
                words_seen++;
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word: got %h vwr=%b, required no word", cmd_pkt, cmd_valid_wr);
                end else begin
                    e = sb.pop_front();
                    if (cmd_pkt !== e.word || cmd_valid_wr !== e.vwr) begin
                        n_err++;
                        $display("FAIL word[%0d]: got %h vwr=%b, required %h vwr=%b",
                                 words_seen, cmd_pkt, cmd_valid_wr, e.word, e.vwr);
                    end
                end
                prev_open = !cmd_valid_wr;
            end else begin
                if (cmd_valid_wr !== 1'b0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL stray_valid_wr: got %b without cmd_wr, required 0", cmd_valid_wr);
                end
                prev_open = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] dw(input int p, input int w);
        return 32'hD000_0000 | 32'(p << 8) | 32'(w);
    endfunction

    function automatic logic [127:0] ld(input int p);
        return {dw(p, 0), dw(p, 1), dw(p, 2), dw(p, 3)};
    endfunction

    task automatic exp_word(input logic [1:0] f, input logic [1:0] b, input logic [31:0] d, input logic v);
        sb.push_back(exp_t'({f, b, d, v}));
    endtask

    task automatic push_line(input logic [138:0] l);
        rx_pkt       = l;
        rx_pkt_wrreq = 1'b1;
        tick();
        rx_pkt_wrreq = 1'b0;
    endtask

    task automatic push_vld(input logic v);
        rx_valid       = v;
        rx_valid_wrreq = 1'b1;
        tick();
        rx_valid_wrreq = 1'b0;
    endtask

    task automatic drain(input string name, input int n);
        repeat (n) tick();
        check(name, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    // Head / mid / tail(4'hF): 12 words, flags 01, 11 x10, 10.
    task automatic send_3line(input int p, input logic v, input bit with_exp);
        push_line({3'b101, 4'h0, 4'h0, ld(p * 4)});
        push_line({3'b100, 8'h00, ld(p * 4 + 1)});
        push_line({3'b110, 4'hF, 4'h0, ld(p * 4 + 2)});
        if (with_exp) begin
            for (int l = 0; l < 3; l++) begin
                for (int w = 0; w < 4; w++) begin
                    if (l == 0 && w == 0)      exp_word(2'b01, 2'b00, dw(p * 4 + l, w), 1'b0);
                    else if (l == 2 && w == 3) exp_word(2'b10, 2'b00, dw(p * 4 + l, w), 1'b1);
                    else                       exp_word(2'b11, 2'b00, dw(p * 4 + l, w), 1'b0);
                end
            end
        end
        push_vld(v);
    endtask

    task automatic send_pkt1();
        push_line({3'b110, 4'h7, 4'h0, 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4});
        exp_word(2'b01, 2'b00, 32'hA1A2A3A4, 1'b0);
        exp_word(2'b10, 2'b00, 32'hB1B2B3B4, 1'b1);
        push_vld(1'b1);
    endtask

    task automatic send_bad();
        push_line({3'b100, 8'h00, ld(40)});
        push_line({3'b110, 4'h3, 4'h0, ld(41)});
        push_vld(1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        reset          = 1'b1;
        rx_pkt         = '0;
        rx_pkt_wrreq   = 1'b0;
        rx_valid       = 1'b0;
        rx_valid_wrreq = 1'b0;
        cmd_afull      = 1'b0;
        repeat (2) tick();
        check("rst_cmd_pkt", 64'(cmd_pkt), 64'd0);
        check("rst_cmd_wr", 64'(cmd_wr), 64'd0);
        check("rst_cmd_valid_wr", 64'(cmd_valid_wr), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_usedw", 64'(rx_pkt_usedw), 64'd0);
        reset = 1'b0;
        tick();

        // 1-line packet, two words
        send_pkt1();
        drain("drain_pkt1", 12);

        // 3-line packet, 12 contiguous words
        send_3line(1, 1'b1, 1'b1);
        drain("drain_3line", 25);

        // 1-line tail, last word index 2, byte count 2
        push_line({3'b110, 4'h9, 4'h0, ld(7)});
        exp_word(2'b01, 2'b00, dw(7, 0), 1'b0);
        exp_word(2'b11, 2'b00, dw(7, 1), 1'b0);
        exp_word(2'b10, 2'b10, dw(7, 2), 1'b1);
        push_vld(1'b1);
        drain("drain_3word", 12);

        // 1-line tail ending on word 0: last flag beats first flag
        push_line({3'b110, 4'h0, 4'h0, ld(8)});
        exp_word(2'b10, 2'b01, dw(8, 0), 1'b1);
        push_vld(1'b1);
        drain("drain_1word", 12);

        // Verdict 0: dropped silently, FIFO emptied, next packet intact
        send_3line(2, 1'b0, 1'b0);
        drain("drain_drop", 20);
        check("drop_usedw", 64'(rx_pkt_usedw), 64'd0);
        send_pkt1();
        drain("drain_after_drop", 12);

        // First line not a head: error count, saturation on the narrow instance
        send_bad();
        drain("drain_bad1", 15);
        check("err_cnt_1", 64'(err_cnt), 64'd1);
        check("sat_err_1", 64'(sat_err_cnt), 64'd1);
        check("bad_usedw", 64'(rx_pkt_usedw), 64'd0);
        for (int i = 0; i < 3; i++) begin
            send_bad();
            repeat (10) tick();
        end
        drain("drain_bad4", 5);
        check("err_cnt_4", 64'(err_cnt), 64'd4);
        check("sat_err_hold", 64'(sat_err_cnt), 64'd3);

        // cmd_afull holds the packet in IDLE; first word one cycle after the pop
        cmd_afull = 1'b1;
        push_line({3'b110, 4'h4, 4'h0, ld(30)});
        exp_word(2'b01, 2'b00, dw(30, 0), 1'b0);
        exp_word(2'b10, 2'b01, dw(30, 1), 1'b1);
        push_vld(1'b1);
        base = words_seen;
        repeat (10) tick();
        check("afull_no_words", 64'(words_seen - base), 64'd0);
        check("afull_usedw", 64'(rx_pkt_usedw), 64'd1);
        cmd_afull = 1'b0;
        tick();
        check("afull_pop_cycle_wr", 64'(cmd_wr), 64'd0);
        tick();
        check("afull_first_word_wr", 64'(cmd_wr), 64'd1);
        drain("drain_afull", 10);

        // Reset after the 5th word of a 3-line packet
        send_3line(3, 1'b1, 1'b1);
        base = words_seen;
        for (int i = 0; i < 60 && words_seen < base + 5; i++) begin
            @(negedge clk);
            #1;
        end
        check("reach_5th_word", 64'(words_seen - base), 64'd5);
        reset = 1'b1;
        sb.delete();
        #1;
        check("midrst_cmd_wr", 64'(cmd_wr), 64'd0);
        check("midrst_cmd_pkt", 64'(cmd_pkt), 64'd0);
        check("midrst_valid_wr", 64'(cmd_valid_wr), 64'd0);
        check("midrst_usedw", 64'(rx_pkt_usedw), 64'd0);
        tick();
        reset = 1'b0;
        check("midrst_err_cnt", 64'(err_cnt), 64'd0);
        tick();
        send_pkt1();
        drain("drain_after_reset", 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
